// File: rtl/toast_fetch_unit_pkg.sv
// Shared definitions for the Toast fetch front end.
// Contents:
//   INSTR_NOP      - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_e  - fetch FSM state encoding
//   OPCODE_*       - RV32I major opcodes used elsewhere in the pipeline
//   pc_next()      - sequential fetch address (wraps at 2^32)
package toast_fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/toast_fetch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with push/pop/clear.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, wdata     - write an entry (ignored when full)
//   pop             - drop the head entry (ignored when empty)
//   clear           - empty the FIFO this edge, wins over push/pop
//   rdata           - head entry (stale when empty)
//   full, empty     - status
//   count           - number of stored entries
// DEPTH must be a power of two so the pointers wrap for free.
module toast_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/toast_fetch_unit.sv
// Instruction-fetch front end: PC generation, pipelined imem requests,
// in-order instruction queue feeding IF/ID, stall/flush/redirect handling.
// Ports:
//   clk_i, reset_i                   - clock, synchronous active-high reset
//   fetch_en_i                       - fetching permitted
//   stall_i, flush_i                 - hold / discard the head entry (flush wins)
//   redirect_en_i, redirect_pc_i     - taken branch/jump and its target
//   imem_req_o, imem_addr_o          - fetch request and address
//   imem_gnt_i                       - request accepted this cycle
//   imem_rvalid_i, imem_rdata_i      - in-order response
//   IF_valid_o, IF_pc_o, IF_instruction_o - head entry for IF/ID (0 / NOP when invalid)
//
// state      | meaning
// FETCH_IDLE | no requests issued; in-flight responses still land
// FETCH_RUN  | requests issued while credits allow
module toast_fetch_unit
  import toast_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_en_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        IF_valid_o,
  output logic [31:0] IF_pc_o,
  output logic [31:0] IF_instruction_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic [31:0]    pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  q_count;
  logic [63:0]    q_rdata;
  logic [31:0]    f_rdata;
  logic           q_empty, q_full, f_empty, f_full;
  logic           q_push, q_pop;
  logic           grant, rsp, credit_ok;

  // The in-flight address FIFO doubles as the outstanding counter; it keeps
  // entries that a redirect has doomed so their responses can be counted off.
  // A response with nothing in flight is a leftover from before reset.
  assign grant = imem_req_o && imem_gnt_i;
  assign rsp   = imem_rvalid_i && !f_empty;

  assign q_pop  = !q_empty && (flush_i || !stall_i);
  assign q_push = rsp && (drop_cnt == '0) && !redirect_en_i;

  // A head entry leaving this cycle frees its slot for a new request.
  assign credit_ok = (int'(outstanding) + int'(q_count)) < (DEPTH + int'(q_pop));

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= FETCH_IDLE;
    else         state <= state_next;
  end

  // An unaccepted request is held until granted, even if fetch_en drops.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE: if (fetch_en_i) state_next = FETCH_RUN;
      FETCH_RUN:  if (!fetch_en_i && !(imem_req_o && !imem_gnt_i)) state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o = (state == FETCH_RUN) && !redirect_en_i && credit_ok;
  end

  assign imem_addr_o = pc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_en_i) begin
      pc       <= redirect_pc_i & ~32'h3;
      drop_cnt <= outstanding - CW'(rsp);
    end else begin
      if (grant) pc <= pc_next(pc);
      if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  toast_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_inflight (
    .clk   (clk_i),
    .reset (reset_i),
    .push  (grant),
    .pop   (rsp),
    .clear (1'b0),
    .wdata (pc),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (outstanding)
  );

  toast_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_queue (
    .clk   (clk_i),
    .reset (reset_i),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect_en_i),
    .wdata ({f_rdata, imem_rdata_i}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign IF_valid_o       = !q_empty && !flush_i;
  assign IF_pc_o          = IF_valid_o ? q_rdata[63:32] : 32'h0;
  assign IF_instruction_o = IF_valid_o ? q_rdata[31:0]  : NOP_INSTR;

  // Credit accounting must make both of these impossible.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(q_push && q_full));
      assert (!(grant && f_full));
    end
  end

endmodule

// File: tb/tb_toast_fetch_unit.sv
module tb_toast_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, fetch_en = 1'b0, stall = 1'b0, flush = 1'b0, redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  always #5 clk = ~clk;

  toast_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .fetch_en_i       (fetch_en),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_en_i    (redir),
    .redirect_pc_i    (rpc),
    .imem_req_o       (req),
    .imem_addr_o      (addr),
    .imem_gnt_i       (gnt),
    .imem_rvalid_i    (rvalid),
    .imem_rdata_i     (rdata),
    .IF_valid_o       (if_valid),
    .IF_pc_o          (if_pc),
    .IF_instruction_o (if_instr)
  );

  int checks = 0, failures = 0, cyc = 0;
  int gnt_pct = 100, lat_min = 0, lat_max = 0;

  // reference model: fetch permission, next fetch pc, addresses in flight,
  // how many of those are doomed, and the IF queue of {pc, instr}
  bit          m_fetch = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] infl[$];
  int          m_drop = 0;
  logic [63:0] mq[$];

  // memory environment: accepted addresses and the cycle each may return
  logic [31:0] mem_addr[$];
  int          mem_rdy[$];
  int          mem_stale = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fe, input bit st, input bit fl,
                      input bit rd, input logic [31:0] rp);
    bit          rv, g, e_valid, e_pop, e_req, rsp;
    logic [31:0] e_pc, e_instr, a;
    logic [63:0] h;
    int          used;
    @(posedge clk);
    #1;
    g  = !rst && (mem_stale == 0) && ($urandom_range(0, 99) < gnt_pct);
    rv = (mem_addr.size() > 0) && (mem_rdy[0] <= cyc);
    reset = rst; fetch_en = fe; stall = st; flush = fl; redir = rd; rpc = rp;
    gnt = g; rvalid = rv;
    rdata = rv ? mdata(mem_addr[0]) : $urandom();

    e_valid = (mq.size() > 0) && !fl;
    e_pop   = (mq.size() > 0) && (fl || !st);
    used    = infl.size() + mq.size() - (e_pop ? 1 : 0);
    e_req   = m_fetch && !rd && (used < DEPTH);
    h       = (mq.size() > 0) ? mq[0] : 64'h0;
    e_pc    = e_valid ? h[63:32] : 32'h0;
    e_instr = e_valid ? h[31:0] : NOP;

    #4;
    s_req = req; s_addr = addr; s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
    if (!rst) begin
      check("imem_req", s_req, e_req);
      if (e_req) check("imem_addr", s_addr, m_pc);
      check("IF_valid", s_valid, e_valid);
      check("IF_pc", s_pc, e_pc);
      check("IF_instruction", s_instr, e_instr);
    end

    if (rv) begin
      void'(mem_addr.pop_front());
      void'(mem_rdy.pop_front());
      if (mem_stale > 0) mem_stale--;
    end
    if (!rst && s_req && g) begin
      mem_addr.push_back(s_addr);
      mem_rdy.push_back(cyc + 1 + int'($urandom_range(lat_min, lat_max)));
    end

    if (rst) begin
      m_fetch = 1'b0; m_pc = RESET_PC; infl.delete(); mq.delete(); m_drop = 0;
      mem_stale = mem_addr.size();
    end else begin
      rsp = rv && (infl.size() > 0);
      if (rd) begin
        if (rsp) void'(infl.pop_front());
        m_drop = infl.size();
        mq.delete();
        m_pc = rp & ~32'h3;
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (rsp) begin
          a = infl.pop_front();
          if (m_drop > 0) m_drop--;
          else mq.push_back({a, rdata});
        end
        if (e_req && g) begin
          infl.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      if (!m_fetch) m_fetch = fe;
      else if (!fe && !(e_req && !g)) m_fetch = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 32'h0);
  endtask

  task automatic first_valid(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(0, 1, 0, 0, 0, 32'h0);
      found = s_valid;
    end
    check({name, "_found"}, 32'(found), 32'd1);
    if (found) begin
      check({name, "_pc"}, s_pc, exp_pc);
      check({name, "_instr"}, s_instr, mdata(exp_pc));
    end
  endtask

  initial begin
    bit rst, fe, st, fl, rd;
    logic [31:0] rp;

    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    check("rst_req", s_req, 32'd0);
    check("rst_addr", s_addr, RESET_PC);
    check("rst_valid", s_valid, 32'd0);
    check("rst_pc", s_pc, 32'h0);
    check("rst_instr", s_instr, NOP);

    // zero-wait memory: first instruction 3 cycles after fetch_en
    step(0, 1, 0, 0, 0, 32'h0); check("lat_req_c0", s_req, 32'd0);
    step(0, 1, 0, 0, 0, 32'h0); check("lat_req_c1", s_req, 32'd1); check("lat_addr_c1", s_addr, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0); check("lat_valid_c2", s_valid, 32'd0);
    step(0, 1, 0, 0, 0, 32'h0); check("seq_pc0", s_pc, 32'h0); check("seq_instr0", s_instr, mdata(32'h0));
    step(0, 1, 0, 0, 0, 32'h0); check("seq_pc4", s_pc, 32'h4); check("seq_valid4", s_valid, 32'd1);
    step(0, 1, 0, 0, 0, 32'h0); check("seq_pc8", s_pc, 32'h8);

    // grant withheld: request and address must hold
    gnt_pct = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 32'h0);
      check("hold_req", s_req, 32'd1);
      check("hold_addr", s_addr, 32'h14);
    end
    gnt_pct = 100;
    run(1);

    // stall until the queue fills, head must not move
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1, 0, 0, 32'h0);
      if (k >= 2) begin
        check("stall_pc", s_pc, 32'h14);
        check("stall_req", s_req, 32'd0);
      end
    end
    step(0, 1, 0, 0, 0, 32'h0); check("resume_pc0", s_pc, 32'h14);
    step(0, 1, 0, 0, 0, 32'h0); check("resume_pc1", s_pc, 32'h18);
    step(0, 1, 0, 0, 0, 32'h0); check("resume_pc2", s_pc, 32'h1C);

    // flush wins over stall
    step(0, 1, 1, 1, 0, 32'h0); check("flush_valid", s_valid, 32'd0);
    step(0, 1, 0, 0, 0, 32'h0); check("flush_next_pc", s_pc, 32'h24);

    // redirect with two responses in flight
    lat_min = 3; lat_max = 3;
    run(2);
    step(0, 1, 0, 0, 1, 32'h100);
    first_valid("redirect", 32'h100);

    // reset with a response still pending
    run(4);
    step(1, 1, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h0);
    check("midrst_req", s_req, 32'd0);
    check("midrst_valid", s_valid, 32'd0);
    check("midrst_addr", s_addr, RESET_PC);
    check("midrst_instr", s_instr, NOP);
    first_valid("midrst_restart", RESET_PC);

    // randomized traffic
    lat_min = 0; lat_max = 3; gnt_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: gnt_pct = 30;
          1: gnt_pct = 70;
          default: gnt_pct = 100;
        endcase
      end
      rst = ($urandom_range(0, 999) < 4);
      fe  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 6);
      rd  = ($urandom_range(0, 99) < 3);
      rp  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_3FFC);
      step(rst, fe, st, fl, rd, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
